// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered immediate-generation stage between fetch and decode.
// Each accepted 32-bit instruction is paired with its XLEN-wide, sign-extended
// immediate. A one-entry skid buffer behind the output register keeps full
// throughput when downstream applies backpressure.
//
// Parameters:
//   XLEN     - immediate width (32 or 64)
//   AUTO_SEL - 0: type taken from imm_sel; 1: type decoded from instr_in[6:0]
// Optional feature macro:
//   IMM_GEN_CSR_EN - enables the Z type (CSR uimm, zero-extended instr[19:15])
// Ports:
//   clk, rst_n             clock, async active-low reset
//   flush                  synchronous kill of all buffered entries
//   in_valid/in_ready      input handshake (in_ready registered)
//   instr_in, imm_sel      raw instruction and type select
//   out_valid/out_ready    output handshake
//   instr_out, imm_out     instruction and its immediate
//   imm_type_out, sel_err  resolved type and reserved/unsupported flag
module imm_gen_stage #(
  parameter int unsigned XLEN     = 32,
  parameter bit          AUTO_SEL = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr_in,
  input  logic [2:0]      imm_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     instr_out,
  output logic [XLEN-1:0] imm_out,
  output logic [2:0]      imm_type_out,
  output logic            sel_err
);

  localparam int unsigned ILEN = 32;

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_I    = 3'b001;
  localparam logic [2:0] SEL_S    = 3'b010;
  localparam logic [2:0] SEL_B    = 3'b011;
  localparam logic [2:0] SEL_U    = 3'b100;
  localparam logic [2:0] SEL_J    = 3'b101;
  localparam logic [2:0] SEL_Z    = 3'b110;
  localparam logic [2:0] SEL_RSVD = 3'b111;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] imm;
    logic [2:0]      typ;
    logic            err;
  } entry_t;

  logic [2:0]      w_sel_dec;
  logic [2:0]      w_sel_raw;
  logic [2:0]      w_typ;
  logic            w_err;
  logic [ILEN-1:0] w_imm32;
  entry_t          w_new;
  logic            w_in_fire;

  entry_t r_out, r_skid;
  logic   r_out_valid, r_skid_valid, r_in_ready;
  entry_t w_out_nxt, w_skid_nxt;
  logic   w_out_valid_nxt, w_skid_valid_nxt;

  // Opcode-to-type decode used when AUTO_SEL is set
  always_comb begin
    w_sel_dec = SEL_NONE;
    case (instr_in[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: w_sel_dec = SEL_I;
      7'b0100011:                         w_sel_dec = SEL_S;
      7'b1100011:                         w_sel_dec = SEL_B;
      7'b0110111, 7'b0010111:             w_sel_dec = SEL_U;
      7'b1101111:                         w_sel_dec = SEL_J;
`ifdef IMM_GEN_CSR_EN
      7'b1110011: if (instr_in[14])       w_sel_dec = SEL_Z;
`endif
      default:                            w_sel_dec = SEL_NONE;
    endcase
  end

  assign w_sel_raw = AUTO_SEL ? w_sel_dec : imm_sel;

  // Every format fits in 32 bits with bit 31 as its sign, so build a 32-bit
  // value and sign-extend once to XLEN.
  always_comb begin
    w_typ   = w_sel_raw;
    w_err   = 1'b0;
    w_imm32 = '0;
    case (w_sel_raw)
      SEL_I: w_imm32 = {{20{instr_in[31]}}, instr_in[31:20]};
      SEL_S: w_imm32 = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
      SEL_B: w_imm32 = {{20{instr_in[31]}}, instr_in[7], instr_in[30:25],
                        instr_in[11:8], 1'b0};
      SEL_U: w_imm32 = {instr_in[31:12], 12'b0};
      SEL_J: w_imm32 = {{12{instr_in[31]}}, instr_in[19:12], instr_in[20],
                        instr_in[30:21], 1'b0};
`ifdef IMM_GEN_CSR_EN
      SEL_Z: w_imm32 = {27'b0, instr_in[19:15]};
`else
      SEL_Z: begin
        w_typ = SEL_NONE;
        w_err = 1'b1;
      end
`endif
      SEL_RSVD: begin
        w_typ = SEL_NONE;
        w_err = 1'b1;
      end
      default: w_imm32 = '0;
    endcase
  end

  assign w_new = '{instr: instr_in,
                   imm:   XLEN'($signed(w_imm32)),
                   typ:   w_typ,
                   err:   w_err};

  assign w_in_fire = in_valid && r_in_ready;

  // Output register + skid entry next-state; flush overrides all handshakes
  always_comb begin
    w_out_nxt        = r_out;
    w_out_valid_nxt  = r_out_valid;
    w_skid_nxt       = r_skid;
    w_skid_valid_nxt = r_skid_valid;
    if (flush) begin
      w_out_valid_nxt  = 1'b0;
      w_skid_valid_nxt = 1'b0;
    end else if (!r_out_valid || out_ready) begin
      if (r_skid_valid) begin
        w_out_nxt        = r_skid;
        w_out_valid_nxt  = 1'b1;
        w_skid_valid_nxt = 1'b0;
      end else if (w_in_fire) begin
        w_out_nxt       = w_new;
        w_out_valid_nxt = 1'b1;
      end else begin
        w_out_valid_nxt = 1'b0;
      end
    end else if (w_in_fire) begin
      w_skid_nxt       = w_new;
      w_skid_valid_nxt = 1'b1;
    end
  end

  // State registers; in_ready mirrors an empty skid entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out        <= '0;
      r_skid       <= '0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else begin
      r_out        <= w_out_nxt;
      r_skid       <= w_skid_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= !w_skid_valid_nxt;
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign instr_out    = r_out.instr;
  assign imm_out      = r_out.imm;
  assign imm_type_out = r_out.typ;
  assign sel_err      = r_out.err;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: one XLEN=32/AUTO_SEL=0 instance and one
// XLEN=64/AUTO_SEL=1 instance share the same input stimulus.
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] instr_in;
  logic [2:0]  imm_sel;
  logic        out_ready;

  logic        m_in_ready, m_out_valid, m_sel_err;
  logic [31:0] m_instr_out, m_imm_out;
  logic [2:0]  m_type;
  logic        a_in_ready, a_out_valid, a_sel_err;
  logic [31:0] a_instr_out;
  logic [63:0] a_imm_out;
  logic [2:0]  a_type;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .AUTO_SEL(1'b0)) u_man32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(m_in_ready),
    .instr_in(instr_in), .imm_sel(imm_sel),
    .out_valid(m_out_valid), .out_ready(out_ready),
    .instr_out(m_instr_out), .imm_out(m_imm_out),
    .imm_type_out(m_type), .sel_err(m_sel_err)
  );

  imm_gen_stage #(.XLEN(64), .AUTO_SEL(1'b1)) u_auto64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready),
    .instr_in(instr_in), .imm_sel(imm_sel),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .instr_out(a_instr_out), .imm_out(a_imm_out),
    .imm_type_out(a_type), .sel_err(a_sel_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one vector, advance one edge, check both instances' outputs
  task automatic stream_vec(input logic [31:0] ins, input logic [2:0] sel,
                            input logic [63:0] m_imm, input logic [2:0] m_typ,
                            input logic m_err,
                            input logic [63:0] a_imm, input logic [2:0] a_typ);
    string t;
    in_valid = 1'b1;
    instr_in = ins;
    imm_sel  = sel;
    step();
    t = $sformatf("%08h", ins);
    chk({t, " m_valid"}, 64'(m_out_valid), 64'd1);
    chk({t, " m_instr"}, 64'(m_instr_out), 64'(ins));
    chk({t, " m_imm"},   64'(m_imm_out),   m_imm);
    chk({t, " m_type"},  64'(m_type),      64'(m_typ));
    chk({t, " m_err"},   64'(m_sel_err),   64'(m_err));
    chk({t, " a_valid"}, 64'(a_out_valid), 64'd1);
    chk({t, " a_imm"},   a_imm_out,        a_imm);
    chk({t, " a_type"},  64'(a_type),      64'(a_typ));
    chk({t, " a_err"},   64'(a_sel_err),   64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    instr_in  = '0;
    imm_sel   = '0;
    out_ready = 1'b1;
    #12;
    chk("rst out_valid", 64'(m_out_valid), 64'd0);
    chk("rst in_ready",  64'(m_in_ready),  64'd1);
    chk("rst sel_err",   64'(m_sel_err),   64'd0);
    chk("rst imm",       64'(m_imm_out),   64'd0);
    chk("rst instr",     64'(m_instr_out), 64'd0);
    chk("rst type",      64'(m_type),      64'd0);
    chk("rst a_imm",     a_imm_out,        64'd0);
    rst_n = 1'b1;

    // Back-to-back stream, out_ready=1: each output follows its input by one cycle
    stream_vec(32'hFFF00093, 3'b001, 64'hFFFFFFFF, 3'b001, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'b001);
    stream_vec(32'h00112623, 3'b010, 64'h0000000C, 3'b010, 1'b0, 64'h000000000000000C, 3'b010);
    stream_vec(32'hFE112E23, 3'b010, 64'hFFFFFFFC, 3'b010, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'b010);
    stream_vec(32'h0000006F, 3'b111, 64'h00000000, 3'b000, 1'b1, 64'h0000000000000000, 3'b101);
    stream_vec(32'hFE000EE3, 3'b011, 64'hFFFFFFFC, 3'b011, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'b011);
    stream_vec(32'hFFDFF0EF, 3'b101, 64'hFFFFFFFC, 3'b101, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'b101);
    stream_vec(32'h800002B7, 3'b100, 64'h80000000, 3'b100, 1'b0, 64'hFFFFFFFF80000000, 3'b100);
    stream_vec(32'h123452B7, 3'b100, 64'h12345000, 3'b100, 1'b0, 64'h0000000012345000, 3'b100);
    stream_vec(32'h40000033, 3'b001, 64'h00000400, 3'b001, 1'b0, 64'h0000000000000000, 3'b000);
    stream_vec(32'h40000033, 3'b000, 64'h00000000, 3'b000, 1'b0, 64'h0000000000000000, 3'b000);
`ifdef IMM_GEN_CSR_EN
    stream_vec(32'h0002D073, 3'b110, 64'h00000005, 3'b110, 1'b0, 64'h0000000000000005, 3'b110);
`else
    stream_vec(32'h0002D073, 3'b110, 64'h00000000, 3'b000, 1'b1, 64'h0000000000000000, 3'b000);
`endif
    in_valid = 1'b0;
    step();
    chk("drain out_valid", 64'(m_out_valid), 64'd0);

    // Backpressure: A, B, C with out_ready low for three cycles
    out_ready = 1'b0;
    imm_sel   = 3'b001;
    in_valid  = 1'b1;
    instr_in  = 32'h00100093;
    step();
    chk("bp A valid",  64'(m_out_valid), 64'd1);
    chk("bp A imm",    64'(m_imm_out),   64'd1);
    chk("bp rdy1",     64'(m_in_ready),  64'd1);
    instr_in = 32'h00200093;
    step();
    chk("bp A hold",   64'(m_instr_out), 64'h00100093);
    chk("bp A imm2",   64'(m_imm_out),   64'd1);
    chk("bp rdy2",     64'(m_in_ready),  64'd0);
    instr_in = 32'h00300093;
    step();
    chk("bp A hold3",  64'(m_instr_out), 64'h00100093);
    chk("bp rdy3",     64'(m_in_ready),  64'd0);
    chk("bp a_rdy3",   64'(a_in_ready),  64'd0);
    out_ready = 1'b1;
    step();
    chk("bp B instr",  64'(m_instr_out), 64'h00200093);
    chk("bp B imm",    64'(m_imm_out),   64'd2);
    chk("bp rdy4",     64'(m_in_ready),  64'd1);
    step();
    chk("bp C instr",  64'(m_instr_out), 64'h00300093);
    chk("bp C imm",    64'(m_imm_out),   64'd3);
    chk("bp a_C imm",  a_imm_out,        64'd3);
    in_valid = 1'b0;
    step();
    chk("bp no dup",   64'(m_out_valid), 64'd0);

    // Flush with output and skid both full; presented input is dropped
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr_in  = 32'h00400093;
    step();
    instr_in  = 32'h00500093;
    step();
    chk("fl full rdy", 64'(m_in_ready),  64'd0);
    flush    = 1'b1;
    instr_in = 32'h00600093;
    step();
    chk("fl out_valid", 64'(m_out_valid), 64'd0);
    chk("fl in_ready",  64'(m_in_ready),  64'd1);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("fl skid gone", 64'(m_out_valid), 64'd0);

    // Flush while ready: the input presented in the flush cycle never appears
    in_valid = 1'b1;
    instr_in = 32'h00700093;
    flush    = 1'b1;
    step();
    chk("fl2 out_valid", 64'(m_out_valid), 64'd0);
    flush    = 1'b0;
    in_valid = 1'b0;
    step();
    chk("fl2 dropped",   64'(m_out_valid), 64'd0);

    // Asynchronous reset mid-stream, checked between clock edges
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr_in  = 32'hFFF00093;
    step();
    instr_in  = 32'h00100093;
    step();
    chk("ar pre valid", 64'(m_out_valid), 64'd1);
    chk("ar pre rdy",   64'(m_in_ready),  64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar out_valid", 64'(m_out_valid), 64'd0);
    chk("ar in_ready",  64'(m_in_ready),  64'd1);
    chk("ar imm",       64'(m_imm_out),   64'd0);
    chk("ar instr",     64'(m_instr_out), 64'd0);
    chk("ar a_imm",     a_imm_out,        64'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    step();
    chk("ar post valid", 64'(m_out_valid), 64'd0);
    step();
    chk("ar post valid2", 64'(m_out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
